matrix_scan_bcm: RTL and testbench

- Parametrised successor to the fixed 64x32 / 6-bit scan generator.
- Drives a HUB75-style panel using binary-coded modulation (BCM) with configurable column count, row-pair count and bit-plane depth.
- Fetches pixel bits through a ready/request handshake with the framebuffer fetch path, and shifts the next bit-plane while the current one is lit.
- Sits between framebuffer_fetch/pixel_split and the panel pins; fm6126init muxing stays outside.

---
 rtl/matrix_scan_bcm.sv | 155 +++++++++++++++
 tb/tb_matrix_scan_bcm.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_bcm.sv
// HUB75 scan generator using binary-coded modulation. While the current bit-plane
// is lit, the next one is shifted in through a ready/request fetch handshake.
module matrix_scan_bcm #(
  parameter int COLUMNS       = 64,
  parameter int COLUMN_WIDTH  = 6,
  parameter int ROW_PAIRS     = 16,
  parameter int ROW_WIDTH     = 4,
  parameter int BITPLANES     = 6,
  parameter int PLANE_WIDTH   = 3,
  parameter int BLANK_TICKS   = 2,
  parameter int BASE_ON_TICKS = 8
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [BITPLANES-1:0]    plane_mask,
  input  logic                    pixel_ready,
  output logic [COLUMN_WIDTH-1:0] column_address,
  output logic [ROW_WIDTH-1:0]    row_address,
  output logic [PLANE_WIDTH-1:0]  bitplane,
  output logic                    pixel_req,
  output logic                    clk_pixel,
  output logic                    row_latch,
  output logic                    output_enable,
  output logic [ROW_WIDTH-1:0]    row_address_active,
  output logic [PLANE_WIDTH-1:0]  bitplane_active,
  output logic                    frame_start
);

  // The longest window is BASE_ON_TICKS << (BITPLANES-1); the extra plane-width bits give headroom.
  localparam int ON_WIDTH    = PLANE_WIDTH + $clog2(BASE_ON_TICKS * (2 ** (BITPLANES - 1)));
  localparam int BLANK_WIDTH = $clog2(BLANK_TICKS + 1);

  localparam logic [COLUMN_WIDTH-1:0] LAST_COL   = COLUMN_WIDTH'(COLUMNS - 1);
  localparam logic [ROW_WIDTH-1:0]    LAST_ROW   = ROW_WIDTH'(ROW_PAIRS - 1);
  localparam logic [PLANE_WIDTH-1:0]  LAST_PLANE = PLANE_WIDTH'(BITPLANES - 1);
  localparam logic [ON_WIDTH-1:0]     BASE_ON    = ON_WIDTH'(BASE_ON_TICKS);
  localparam logic [BLANK_WIDTH-1:0]  BLANK_LOAD = BLANK_WIDTH'(BLANK_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_WAIT_ON, S_BLANK, S_LATCH, S_HALT
  } state_t;

  state_t                  state_q, state_d;
  logic [COLUMN_WIDTH-1:0] column_q, column_d;
  logic [ROW_WIDTH-1:0]    row_q, row_d, row_active_q, row_active_d;
  logic [PLANE_WIDTH-1:0]  plane_q, plane_d, plane_active_q, plane_active_d;
  logic [ON_WIDTH-1:0]     on_q, on_d;
  logic [BLANK_WIDTH-1:0]  blank_q, blank_d;
  logic                    mask_on, oe_d;
  logic                    clk_pixel_q, pixel_req_q, row_latch_q, oe_q, frame_start_q;

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    column_d       = column_q;
    row_d          = row_q;
    plane_d        = plane_q;
    row_active_d   = row_active_q;
    plane_active_d = plane_active_q;
    blank_d        = blank_q;
    // The ON window runs down regardless of state; LATCH reloads it below.
    on_d           = (on_q != '0) ? on_q - 1'b1 : on_q;

    case (state_q)
      S_IDLE:     if (enable) state_d = S_SHIFT_LO;
      S_SHIFT_LO: if (pixel_ready) state_d = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (column_q == LAST_COL) begin
          column_d = '0;
          state_d  = S_WAIT_ON;
        end else begin
          column_d = column_q + 1'b1;
          state_d  = S_SHIFT_LO;
        end
      end
      S_WAIT_ON: begin
        if (on_q == '0) begin
          state_d = S_BLANK;
          blank_d = BLANK_LOAD;
        end
      end
      S_BLANK: begin
        if (blank_q == '0) state_d = S_LATCH;
        else               blank_d = blank_q - 1'b1;
      end
      S_LATCH: begin
        row_active_d   = row_q;
        plane_active_d = plane_q;
        on_d           = BASE_ON << plane_q;
        if (plane_q == LAST_PLANE) begin
          plane_d = '0;
          row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end else begin
          plane_d = plane_q + 1'b1;
        end
        state_d = enable ? S_SHIFT_LO : S_HALT;
      end
      S_HALT:     if (enable) state_d = S_SHIFT_LO;
      default:    state_d = S_IDLE;
    endcase

    mask_on = 1'b0;
    for (int i = 0; i < BITPLANES; i++) begin
      if (plane_active_d == PLANE_WIDTH'(i)) mask_on = plane_mask[i];
    end
    // A masked plane keeps its window length; only OE is held low.
    oe_d = (on_d != '0) && mask_on && (state_d != S_BLANK) && (state_d != S_LATCH);
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      column_q       <= '0;
      row_q          <= '0;
      plane_q        <= '0;
      row_active_q   <= '0;
      plane_active_q <= '0;
      on_q           <= '0;
      blank_q        <= '0;
      clk_pixel_q    <= 1'b0;
      pixel_req_q    <= 1'b0;
      row_latch_q    <= 1'b0;
      oe_q           <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      column_q       <= column_d;
      row_q          <= row_d;
      plane_q        <= plane_d;
      row_active_q   <= row_active_d;
      plane_active_q <= plane_active_d;
      on_q           <= on_d;
      blank_q        <= blank_d;
      clk_pixel_q    <= (state_d == S_SHIFT_HI);
      pixel_req_q    <= (state_d == S_SHIFT_LO);
      row_latch_q    <= (state_d == S_LATCH);
      oe_q           <= oe_d;
      frame_start_q  <= (state_d == S_LATCH) && (row_q == '0) && (plane_q == '0);
    end
  end

  assign column_address     = column_q;
  assign row_address        = row_q;
  assign bitplane           = plane_q;
  assign pixel_req          = pixel_req_q;
  assign clk_pixel          = clk_pixel_q;
  assign row_latch          = row_latch_q;
  assign output_enable      = oe_q;
  assign row_address_active = row_active_q;
  assign bitplane_active    = plane_active_q;
  assign frame_start        = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Bench for matrix_scan_bcm: latch timing, order, OE widths and frame_start are predicted
// from a transaction-level model of shift, window, blank and latch durations.
module tb_matrix_scan_bcm;

  localparam int COLS  = 4;
  localparam int RP    = 2;
  localparam int BP    = 2;
  localparam int BLANK = 2;
  localparam int BASE  = 8;
  localparam int MAXC  = 20000;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pixel_ready = 1'b1;
  logic [1:0] plane_mask = 2'b11;
  logic [1:0] column_address;
  logic [0:0] row_address, row_address_active, bitplane, bitplane_active;
  logic       pixel_req, clk_pixel, row_latch, output_enable, frame_start;

  logic       enable6 = 1'b0;
  logic [5:0] mask6 = 6'h3F;
  logic [5:0] col6;
  logic [3:0] row6, row_act6;
  logic [2:0] plane6, plane_act6;
  logic       req6, clkp6, latch6, oe6, fs6;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit ready_tab [MAXC];

  int mon_cyc[$], mon_row[$], mon_plane[$], mon_fs[$], mon_oe[$];
  int oe_acc = 0, fs_total = 0;
  int q6_plane[$], q6_oe[$];
  int oe6_acc = 0;
  int exp_cyc[16], exp_row[16], exp_plane[16], exp_fs[16], exp_oe[16];

  matrix_scan_bcm #(
    .COLUMNS(COLS), .COLUMN_WIDTH(2), .ROW_PAIRS(RP), .ROW_WIDTH(1), .BITPLANES(BP),
    .PLANE_WIDTH(1), .BLANK_TICKS(BLANK), .BASE_ON_TICKS(BASE)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .plane_mask(plane_mask),
    .pixel_ready(pixel_ready), .column_address(column_address), .row_address(row_address),
    .bitplane(bitplane), .pixel_req(pixel_req), .clk_pixel(clk_pixel), .row_latch(row_latch),
    .output_enable(output_enable), .row_address_active(row_address_active),
    .bitplane_active(bitplane_active), .frame_start(frame_start)
  );

  matrix_scan_bcm #(
    .COLUMNS(4), .ROW_PAIRS(2), .BITPLANES(6), .BASE_ON_TICKS(1)
  ) dut6 (
    .clk_in(clk_in), .reset(reset), .enable(enable6), .plane_mask(mask6),
    .pixel_ready(1'b1), .column_address(col6), .row_address(row6),
    .bitplane(plane6), .pixel_req(req6), .clk_pixel(clkp6), .row_latch(latch6),
    .output_enable(oe6), .row_address_active(row_act6),
    .bitplane_active(plane_act6), .frame_start(fs6)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Value presented during cycle n is what the DUT samples at the edge closing cycle n.
  initial forever begin
    @(negedge clk_in);
    pixel_ready = (cyc < MAXC) ? ready_tab[cyc] : 1'b1;
  end

  initial forever begin
    @(negedge clk_in);
    if (reset) begin
      if (output_enable) oe_acc++;
      if (frame_start) fs_total++;
      if (row_latch) begin
        mon_cyc.push_back(cyc);
        mon_row.push_back(int'(row_address));
        mon_plane.push_back(int'(bitplane));
        mon_fs.push_back(int'(frame_start));
        mon_oe.push_back(oe_acc);
        oe_acc = 0;
      end
      if (oe6) oe6_acc++;
      if (latch6) begin
        q6_plane.push_back(int'(plane6));
        q6_oe.push_back(oe6_acc);
        oe6_acc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "watchdog");
  end

  function automatic bit ready_at(input int c);
    return (c < MAXC) ? ready_tab[c] : 1'b1;
  endfunction

  // Last cycle of the shift that starts at 'start': each column waits for ready, then takes 2 cycles.
  function automatic int shift_end(input int start);
    int c;
    c = start;
    for (int col = 0; col < COLS; col++) begin
      while (!ready_at(c)) c++;
      c += 2;
    end
    return c - 1;
  endfunction

  // Latch k happens BLANK+1 cycles after both the shift and the previous window have finished.
  task automatic predict(input int e, input int n, input int halt_k, input int resume);
    int last, win, row, plane, prev, start, s, c;
    last = e; win = 0; row = 0; plane = 0; prev = 0;
    for (int k = 0; k < n; k++) begin
      start = (halt_k >= 0 && k == halt_k + 1) ? resume + 1 : last + 1;
      s = shift_end(start);
      c = (s + 1 > last + win + 1) ? s + 1 : last + win + 1;
      exp_cyc[k]   = c + BLANK + 1;
      exp_row[k]   = row;
      exp_plane[k] = plane;
      exp_fs[k]    = (row == 0 && plane == 0) ? 1 : 0;
      exp_oe[k]    = (k == 0) ? 0 : (plane_mask[prev] ? win : 0);
      last = exp_cyc[k];
      win  = BASE << plane;
      prev = plane;
      if (plane == BP - 1) begin
        plane = 0;
        row   = (row + 1) % RP;
      end else begin
        plane++;
      end
    end
  endtask

  task automatic do_reset;
    @(negedge clk_in);
    reset = 1'b0; enable = 1'b0; enable6 = 1'b0;
    for (int i = 0; i < MAXC; i++) ready_tab[i] = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    mon_cyc.delete(); mon_row.delete(); mon_plane.delete(); mon_fs.delete(); mon_oe.delete();
    q6_plane.delete(); q6_oe.delete();
    oe_acc = 0; fs_total = 0; oe6_acc = 0;
  endtask

  task automatic start_scan(output int e);
    @(negedge clk_in);
    enable = 1'b1;
    e = cyc;
  endtask

  task automatic wait_latches(input int n, input string name);
    int t;
    t = 0;
    while (mon_cyc.size() < n && t < 3000) begin
      @(negedge clk_in);
      t++;
    end
    checks++;
    if (mon_cyc.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: latches seen %0d required %0d", name, mon_cyc.size(), n);
    end
  endtask

  function automatic int main_outs();
    return int'({column_address, row_address, bitplane, pixel_req, clk_pixel, row_latch,
                 output_enable, row_address_active, bitplane_active, frame_start});
  endfunction

  task automatic test_reset;
    @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (main_outs() !== 0) begin
      errors++; $display("FAIL reset_outputs: got %0h required 0", main_outs());
    end
    checks++;
    if ({oe6, latch6, clkp6, req6, col6, row6, plane6} !== '0) begin
      errors++; $display("FAIL reset_outputs6: got %0h required 0", {oe6, latch6, clkp6, req6, col6, row6, plane6});
    end
    reset = 1'b1;
    repeat (10) @(negedge clk_in);
    checks++;
    if (main_outs() !== 0 || mon_cyc.size() != 0) begin
      errors++; $display("FAIL idle_hold: outputs %0h latches %0d required 0 and 0", main_outs(), mon_cyc.size());
    end
  endtask

  task automatic test_sequence;
    int e;
    do_reset();
    plane_mask = 2'b11;
    start_scan(e);
    predict(e, 5, -1, e);
    wait_latches(5, "seq");
    checks++;
    if (mon_cyc.size() > 0 && mon_cyc[0] - e !== 12) begin
      errors++; $display("FAIL seq_first_latch: got %0d cycles required 12", mon_cyc[0] - e);
    end
    for (int k = 0; k < mon_cyc.size() && k < 5; k++) begin
      checks++;
      if (mon_cyc[k] !== exp_cyc[k]) begin
        errors++; $display("FAIL seq_cycle[%0d]: got %0d required %0d", k, mon_cyc[k], exp_cyc[k]);
      end
      checks++;
      if (mon_row[k] !== exp_row[k] || mon_plane[k] !== exp_plane[k]) begin
        errors++; $display("FAIL seq_order[%0d]: got (%0d,%0d) required (%0d,%0d)", k,
                           mon_row[k], mon_plane[k], exp_row[k], exp_plane[k]);
      end
      checks++;
      if (mon_fs[k] !== exp_fs[k]) begin
        errors++; $display("FAIL seq_frame_start[%0d]: got %0d required %0d", k, mon_fs[k], exp_fs[k]);
      end
      checks++;
      if (mon_oe[k] !== exp_oe[k]) begin
        errors++; $display("FAIL seq_oe[%0d]: got %0d required %0d", k, mon_oe[k], exp_oe[k]);
      end
    end
    checks++;
    if (fs_total !== 2) begin
      errors++; $display("FAIL seq_frame_count: got %0d required 2", fs_total);
    end
  endtask

  task automatic test_stall;
    int e, l0;
    do_reset();
    plane_mask = 2'b11;
    start_scan(e);
    predict(e, 1, -1, e);
    l0 = exp_cyc[0];
    for (int i = 5; i < 10; i++) ready_tab[l0 + i] = 1'b0;
    predict(e, 3, -1, e);
    while (cyc < l0 + 5) @(negedge clk_in);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (pixel_req !== 1'b1 || clk_pixel !== 1'b0 || column_address !== 2'd2) begin
        errors++; $display("FAIL stall_hold[%0d]: req %0b clk %0b col %0d required 1 0 2", i,
                           pixel_req, clk_pixel, column_address);
      end
      @(negedge clk_in);
    end
    checks++;
    if (clk_pixel !== 1'b1) begin
      errors++; $display("FAIL stall_release: clk_pixel %0b required 1", clk_pixel);
    end
    @(negedge clk_in);
    checks++;
    if (output_enable !== 1'b0) begin
      errors++; $display("FAIL stall_dark: output_enable %0b required 0", output_enable);
    end
    wait_latches(3, "stall");
    for (int k = 1; k < mon_cyc.size() && k < 3; k++) begin
      checks++;
      if (mon_cyc[k] !== exp_cyc[k] || mon_oe[k] !== exp_oe[k]) begin
        errors++; $display("FAIL stall_latch[%0d]: cycle %0d oe %0d required %0d %0d", k,
                           mon_cyc[k], mon_oe[k], exp_cyc[k], exp_oe[k]);
      end
    end
  endtask

  task automatic test_mask;
    int e;
    do_reset();
    plane_mask = 2'b10;
    start_scan(e);
    predict(e, 5, -1, e);
    wait_latches(5, "mask");
    for (int k = 1; k < mon_cyc.size() && k < 5; k++) begin
      checks++;
      if (mon_cyc[k] !== exp_cyc[k] || mon_oe[k] !== exp_oe[k]) begin
        errors++; $display("FAIL mask_window[%0d]: cycle %0d oe %0d required %0d %0d", k,
                           mon_cyc[k], mon_oe[k], exp_cyc[k], exp_oe[k]);
      end
    end
    plane_mask = 2'b11;
  endtask

  task automatic test_halt;
    int e, r;
    do_reset();
    plane_mask = 2'b11;
    start_scan(e);
    wait_latches(2, "halt_pre");
    if (mon_cyc.size() >= 2) while (cyc < mon_cyc[1] + 3) @(negedge clk_in);
    enable = 1'b0;
    wait_latches(3, "halt_latch");
    repeat (40) @(negedge clk_in);
    checks++;
    if (mon_cyc.size() !== 3 || output_enable !== 1'b0 || oe_acc !== 8) begin
      errors++; $display("FAIL halt_state: latches %0d oe %0b oe_cycles %0d required 3 0 8",
                         mon_cyc.size(), output_enable, oe_acc);
    end
    checks++;
    if (row_address !== 1'b1 || bitplane !== 1'b1 || pixel_req !== 1'b0) begin
      errors++; $display("FAIL halt_position: row %0d plane %0d req %0b required 1 1 0",
                         row_address, bitplane, pixel_req);
    end
    enable = 1'b1;
    r = cyc;
    predict(e, 5, 2, r);
    wait_latches(5, "halt_resume");
    for (int k = 0; k < mon_cyc.size() && k < 5; k++) begin
      checks++;
      if (mon_cyc[k] !== exp_cyc[k] || mon_row[k] !== exp_row[k] || mon_plane[k] !== exp_plane[k]
          || mon_oe[k] !== exp_oe[k]) begin
        errors++; $display("FAIL halt_seq[%0d]: got c%0d (%0d,%0d) oe%0d required c%0d (%0d,%0d) oe%0d", k,
                           mon_cyc[k], mon_row[k], mon_plane[k], mon_oe[k],
                           exp_cyc[k], exp_row[k], exp_plane[k], exp_oe[k]);
      end
    end
  endtask

  task automatic test_reset_midop;
    int e, t;
    do_reset();
    plane_mask = 2'b11;
    start_scan(e);
    t = 0;
    while (!(bitplane_active === 1'b1 && output_enable === 1'b1) && t < 300) begin
      @(negedge clk_in);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++; $display("FAIL midop_find: plane-1 OE not seen within %0d cycles", t);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (main_outs() !== 0) begin
      errors++; $display("FAIL midop_async_reset: outputs %0h required 0", main_outs());
    end
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    mon_cyc.delete(); mon_row.delete(); mon_plane.delete(); mon_fs.delete(); mon_oe.delete();
    oe_acc = 0; fs_total = 0;
    e = cyc;
    predict(e, 1, -1, e);
    wait_latches(1, "midop");
    checks++;
    if (mon_cyc.size() > 0 && (mon_cyc[0] !== exp_cyc[0] || mon_row[0] !== 0 || mon_plane[0] !== 0
        || mon_fs[0] !== 1)) begin
      errors++; $display("FAIL midop_first_latch: c%0d (%0d,%0d) fs%0d required c%0d (0,0) fs1",
                         mon_cyc[0], mon_row[0], mon_plane[0], mon_fs[0], exp_cyc[0]);
    end
  endtask

  task automatic test_random;
    int e, base;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      plane_mask = 2'($urandom_range(0, 3));
      base = cyc;
      for (int i = 1; i < 800; i++) ready_tab[base + i] = ($urandom_range(0, 2) != 0);
      start_scan(e);
      predict(e, 8, -1, e);
      wait_latches(8, "rand");
      for (int k = 0; k < mon_cyc.size() && k < 8; k++) begin
        checks++;
        if (mon_cyc[k] !== exp_cyc[k] || mon_row[k] !== exp_row[k] || mon_plane[k] !== exp_plane[k]
            || mon_oe[k] !== exp_oe[k] || mon_fs[k] !== exp_fs[k]) begin
          errors++; $display("FAIL rand%0d[%0d]: got c%0d (%0d,%0d) oe%0d fs%0d required c%0d (%0d,%0d) oe%0d fs%0d",
                             it, k, mon_cyc[k], mon_row[k], mon_plane[k], mon_oe[k], mon_fs[k],
                             exp_cyc[k], exp_row[k], exp_plane[k], exp_oe[k], exp_fs[k]);
        end
      end
    end
    plane_mask = 2'b11;
  endtask

  task automatic test_deep_planes;
    int t;
    do_reset();
    @(negedge clk_in);
    enable6 = 1'b1;
    t = 0;
    while (q6_oe.size() < 7 && t < 3000) begin
      @(negedge clk_in);
      t++;
    end
    checks++;
    if (q6_oe.size() < 7) begin
      errors++; $display("FAIL deep_timeout: latches seen %0d required 7", q6_oe.size());
    end
    for (int p = 0; p < 6 && p + 1 < q6_oe.size(); p++) begin
      checks++;
      if (q6_plane[p] !== p || q6_oe[p + 1] !== (1 << p)) begin
        errors++; $display("FAIL deep_plane%0d: plane %0d oe %0d required %0d %0d", p,
                           q6_plane[p], q6_oe[p + 1], p, 1 << p);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) ready_tab[i] = 1'b1;
    test_reset();
    test_sequence();
    test_stall();
    test_mask();
    test_halt();
    test_reset_midop();
    test_random();
    test_deep_planes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
